// File: rtl/seq_loader_if.sv
// Character-stream load port and base read port of seq_loader.
// master drives requests and characters; slave is the loader.
interface seq_loader_if #(
  parameter int AW = 7
);
  logic          start;
  logic [7:0]    char_in;
  logic          char_valid;
  logic          char_last;
  logic          char_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data;
  logic [AW:0]   len;
  logic          done;
  logic          busy;
  logic          err;

  modport master (
    output start, char_in, char_valid, char_last, rd_en, rd_addr,
    input  char_ready, rd_data, len, done, busy, err
  );

  modport slave (
    input  start, char_in, char_valid, char_last, rd_en, rd_addr,
    output char_ready, rd_data, len, done, busy, err
  );
endinterface

// File: rtl/seq_loader.sv
// Loads an ASCII nucleotide string into a 3-bit code memory and serves registered reads.
// Define SEQ_LOADER_LOWERCASE_EN to also accept lowercase g/t/a/c as bases.
module seq_loader #(
  parameter int MAX_LEN = 128,
  parameter int AW      = 7
) (
  input logic         clk,
  input logic         rst,
  seq_loader_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [AW:0] LEN_LAST = (AW+1)'(MAX_LEN - 1);
  localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LEN_ZERO = (AW+1)'(0);

  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic [AW:0] len_r;
  logic [AW:0] len_s;
  logic        err_r;
  logic        err_s;
  logic        done_r;
  logic        busy_r;
  logic [2:0]  rd_data_r;
  logic [2:0]  code_s;
  logic        eol_s;
  logic        accept_s;
  logic        store_s;
  logic [2:0]  mem_r [MAX_LEN];

  // Map an ASCII character to its base code; 0 means "not a base".
  function automatic logic [2:0] base_code(input logic [7:0] c);
    logic [2:0] code;
    case (c)
      8'h47:   code = 3'd1;
      8'h54:   code = 3'd2;
      8'h41:   code = 3'd3;
      8'h43:   code = 3'd4;
`ifdef SEQ_LOADER_LOWERCASE_EN
      8'h67:   code = 3'd1;
      8'h74:   code = 3'd2;
      8'h61:   code = 3'd3;
      8'h63:   code = 3'd4;
`endif
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  // Next-state, length and error-flag computation.
  always_comb begin
    state_s  = state_r;
    len_s    = len_r;
    err_s    = err_r;
    code_s   = base_code(bus.char_in);
    eol_s    = (bus.char_in == 8'h0A) || (bus.char_in == 8'h0D);
    // ready is only high in LOAD, so busy_r doubles as the accept qualifier
    accept_s = bus.char_valid && busy_r;
    store_s  = accept_s && (code_s != 3'd0);
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          state_s = LOAD;
          len_s   = LEN_ZERO;
          err_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      LOAD: begin
        if (store_s) begin
          len_s = len_r + LEN_ONE;
        end else if (accept_s && !eol_s) begin
          err_s = 1'b1;
        end else begin
          len_s = len_r;
        end
        if (accept_s && (bus.char_last || (store_s && (len_r == LEN_LAST)))) begin
          state_s = DONE;
        end else begin
          state_s = LOAD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      len_r   <= LEN_ZERO;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      len_r   <= len_s;
      err_r   <= err_s;
      done_r  <= (state_s == DONE);
      busy_r  <= (state_s == LOAD);
    end
  end

  // Base storage; contents survive reset and are masked by len.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[len_r[IW-1:0]] <= code_s;
    end
  end

  // Registered read port; returns 0 outside DONE or beyond len.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r <= 3'd0;
    end else if (bus.rd_en) begin
      if ((state_r == DONE) && ({1'b0, bus.rd_addr} < len_r)) begin
        rd_data_r <= mem_r[bus.rd_addr[IW-1:0]];
      end else begin
        rd_data_r <= 3'd0;
      end
    end
  end

  assign bus.char_ready = busy_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.len        = len_r;
  assign bus.err        = err_r;
  assign bus.rd_data    = rd_data_r;
endmodule

// File: tb/tb_seq_loader.sv
// Random and directed bench for seq_loader: a full-size and a MAX_LEN=4 instance share
// one stimulus stream and are checked every cycle against a behavioural model.
module tb_seq_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] ch;
  logic       cv;
  logic       cl;
  logic       rden;
  logic [6:0] rdaddr;
  bit         chk_en = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  seq_loader_if #(.AW(7)) a_if ();
  seq_loader_if #(.AW(7)) b_if ();

  assign a_if.start = start;  assign b_if.start = start;
  assign a_if.char_in = ch;   assign b_if.char_in = ch;
  assign a_if.char_valid = cv; assign b_if.char_valid = cv;
  assign a_if.char_last = cl; assign b_if.char_last = cl;
  assign a_if.rd_en = rden;   assign b_if.rd_en = rden;
  assign a_if.rd_addr = rdaddr; assign b_if.rd_addr = rdaddr;

  seq_loader #(.MAX_LEN(128), .AW(7)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  seq_loader #(.MAX_LEN(4),   .AW(7)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 loading, 2 complete.
  int mode_m [2];
  int len_m  [2];
  int err_m  [2];
  int rd_m   [2];
  int mem_m  [2][128];
  int maxl   [2] = '{128, 4};

  function automatic int spec_code(input logic [7:0] c);
    string bases = "GTAC";
    for (int k = 0; k < 4; k++) begin
      if (c == bases[k]) return k + 1;
`ifdef SEQ_LOADER_LOWERCASE_EN
      if (c == (bases[k] + 8'd32)) return k + 1;
`endif
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode_m[i] = 0; len_m[i] = 0; err_m[i] = 0; rd_m[i] = 0;
    end
  endtask

  task automatic model_step();
    int code;
    for (int i = 0; i < 2; i++) begin
      if (rden) rd_m[i] = (mode_m[i] == 2 && int'(rdaddr) < len_m[i]) ? mem_m[i][rdaddr] : 0;
      if (mode_m[i] != 1) begin
        if (start) begin mode_m[i] = 1; len_m[i] = 0; err_m[i] = 0; end
      end else if (cv) begin
        code = spec_code(ch);
        if (code != 0) begin mem_m[i][len_m[i]] = code; len_m[i]++; end
        else if (ch != 8'h0A && ch != 8'h0D) err_m[i] = 1;
        if (cl || len_m[i] == maxl[i]) mode_m[i] = 2;
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input string p, input int rdy, input int bsy,
                          input int dn, input int ln, input int er, input int rd);
    cmp({p, ".char_ready"}, rdy, int'(mode_m[i] == 1));
    cmp({p, ".busy"},       bsy, int'(mode_m[i] == 1));
    cmp({p, ".done"},       dn,  int'(mode_m[i] == 2));
    cmp({p, ".len"},        ln,  len_m[i]);
    cmp({p, ".err"},        er,  err_m[i]);
    cmp({p, ".rd_data"},    rd,  rd_m[i]);
  endtask

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, "a", int'(a_if.char_ready), int'(a_if.busy), int'(a_if.done),
               int'(a_if.len), int'(a_if.err), int'(a_if.rd_data));
      cmp_inst(1, "b", int'(b_if.char_ready), int'(b_if.busy), int'(b_if.done),
               int'(b_if.len), int'(b_if.err), int'(b_if.rd_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; cv = 1'b0; cl = 1'b0; ch = 8'h00; rden = 1'b0; rdaddr = 7'd0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_at_end);
    for (int k = 0; k < s.len(); k++) begin
      ch = s[k]; cv = 1'b1; cl = last_at_end && (k == s.len() - 1);
      tick();
    end
    cv = 1'b0; cl = 1'b0;
  endtask

  task automatic rd(input int addr);
    rden = 1'b1; rdaddr = 7'(addr); tick(); rden = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle, released mid-cycle after one edge.
  task automatic pulse_reset(input bit check_now);
    clear_inputs();
    #2 rst = 1'b0;
    model_reset();
    #1;
    if (check_now) begin
      cmp("rst.ready", int'(a_if.char_ready), 0);
      cmp("rst.busy",  int'(a_if.busy), 0);
      cmp("rst.done",  int'(a_if.done), 0);
      cmp("rst.len",   int'(a_if.len), 0);
      cmp("rst.err",   int'(a_if.err), 0);
      cmp("rst.rd",    int'(a_if.rd_data), 0);
      cmp("rst.b_len", int'(b_if.len), 0);
    end
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    int exp_a [5] = '{1, 3, 2, 4, 0};
    int exp_b [3] = '{1, 3, 2};
    string pool = "GTACgtacXZ\n\r";
    rst = 1'b0;
    clear_inputs();
    model_reset();
    #3;
    cmp("reset.len",  int'(a_if.len), 0);
    cmp("reset.busy", int'(a_if.busy), 0);
    cmp("reset.done", int'(a_if.done), 0);
    cmp("reset.rd",   int'(a_if.rd_data), 0);
    chk_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    tick();

    // GATC, last on C
    do_start();
    send_str("GATC", 1'b1);
    cmp("gatc.done", int'(a_if.done), 1);
    cmp("gatc.len",  int'(a_if.len), 4);
    cmp("gatc.err",  int'(a_if.err), 0);
    for (int k = 0; k < 5; k++) begin
      rd(k);
      cmp($sformatf("gatc.rd%0d", k), int'(a_if.rd_data), exp_a[k]);
    end
    rden = 1'b0; rdaddr = 7'd0; tick();
    cmp("gatc.hold", int'(a_if.rd_data), 0);

    // newline dropped, X flagged, T last
    do_start();
    send_str("GA\nXT", 1'b1);
    cmp("mix.len", int'(a_if.len), 3);
    cmp("mix.err", int'(a_if.err), 1);
    for (int k = 0; k < 3; k++) begin
      rd(k);
      cmp($sformatf("mix.rd%0d", k), int'(a_if.rd_data), exp_b[k]);
    end

    // six A without last: the MAX_LEN=4 instance fills up
    do_start();
    send_str("AAAAAA", 1'b0);
    cmp("full.b_len",   int'(b_if.len), 4);
    cmp("full.b_done",  int'(b_if.done), 1);
    cmp("full.b_ready", int'(b_if.char_ready), 0);
    cmp("full.a_len",   int'(a_if.len), 6);
    for (int k = 0; k < 5; k++) begin
      rd(k);
      cmp($sformatf("full.b_rd%0d", k), int'(b_if.rd_data), (k < 4) ? 3 : 0);
      cmp($sformatf("full.a_rd%0d", k), int'(a_if.rd_data), 0);
    end

    // start ignored while loading; reset after two characters
    do_start();
    send_str("GT", 1'b0);
    cmp("midload.a_len", int'(a_if.len), 8);
    pulse_reset(1'b1);
    do_start();
    send_str("C", 1'b1);
    cmp("after_rst.len", int'(a_if.len), 1);
    rd(0);
    cmp("after_rst.rd0", int'(a_if.rd_data), 4);

    // start together with a valid character in DONE: the character is not taken
    start = 1'b1; cv = 1'b1; ch = 8'h47; tick();
    start = 1'b0; cv = 1'b0; tick();
    cmp("start_cv.len", int'(a_if.len), 0);
    cmp("start_cv.busy", int'(a_if.busy), 1);
    cl = 1'b0;
    send_str("A", 1'b1);

    // lowercase handling
    do_start();
    send_str("gc", 1'b1);
`ifdef SEQ_LOADER_LOWERCASE_EN
    cmp("lower.len", int'(a_if.len), 2);
    cmp("lower.err", int'(a_if.err), 0);
    rd(0); cmp("lower.rd0", int'(a_if.rd_data), 1);
    rd(1); cmp("lower.rd1", int'(a_if.rd_data), 4);
`else
    cmp("lower.len", int'(a_if.len), 0);
    cmp("lower.err", int'(a_if.err), 1);
`endif

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset(1'b0);
      end else begin
        start  = ($urandom_range(0, 19) == 0);
        cv     = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 7) == 0) ch = 8'($urandom_range(0, 255));
        else ch = pool[$urandom_range(0, 11)];
        cl     = ($urandom_range(0, 11) == 0);
        rden   = $urandom_range(0, 1) == 1;
        rdaddr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
        tick();
      end
    end
    clear_inputs();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
